// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM register bank.
package arm_pkg;

  typedef logic [3:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  localparam reg_addr_t REG_PC = 4'd15;
  localparam reg_addr_t REG_LR = 4'd14;

  localparam word_t PC_READ_OFFSET = 32'd8;
  localparam word_t PC_STEP        = 32'd4;

  localparam int unsigned NUM_GPR  = 15;
  localparam int unsigned GPR_BITS = NUM_GPR * 32;

  // PC loads are always word aligned.
  function automatic word_t align_pc(word_t value);
    return {value[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/arm_rf_read_port.sv
// One combinational register-file read port; R15 reads return PC + 8.
// With ARM_RF_BYPASS_EN defined, same-cycle writes are forwarded to the read data.
module arm_rf_read_port
  import arm_pkg::*;
(
  input  logic [3:0]          rd_addr,
  input  logic [GPR_BITS-1:0] gpr,
  input  logic [31:0]         pc,
`ifdef ARM_RF_BYPASS_EN
  input  logic [31:0]         pc_next,
  input  logic                wr_en_1,
  input  logic [3:0]          wr_addr_1,
  input  logic [31:0]         wr_data_1,
  input  logic                wr_en_2,
  input  logic [3:0]          wr_addr_2,
  input  logic [31:0]         wr_data_2,
`endif
  output logic [31:0]         rd_data
);

  always_comb begin
    rd_data = pc + PC_READ_OFFSET;
    for (int i = 0; i < NUM_GPR; i++) begin
      if (rd_addr == reg_addr_t'(i)) begin
        rd_data = gpr[i*32 +: 32];
      end
    end
`ifdef ARM_RF_BYPASS_EN
    // R15 forwards the resolved next PC; port 1 beats port 2 on a shared target.
    if (rd_addr == REG_PC) begin
      rd_data = pc_next + PC_READ_OFFSET;
    end else if (wr_en_1 && (wr_addr_1 == rd_addr)) begin
      rd_data = wr_data_1;
    end else if (wr_en_2 && (wr_addr_2 == rd_addr)) begin
      rd_data = wr_data_2;
    end
`endif
  end

endmodule

// File: rtl/arm_reg_bank.sv
// ARM7-style register bank: R0-R14, PC (R15) and CPSR, four read and two write ports.
// Optional same-cycle write forwarding is enabled by defining ARM_RF_BYPASS_EN.
module arm_reg_bank
  import arm_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter logic [31:0] CPSR_RESET = 32'h0000_00D3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_en,
  input  logic [3:0]  rd_addr_1,
  input  logic [3:0]  rd_addr_2,
  input  logic [3:0]  rd_addr_3,
  input  logic [3:0]  rd_addr_4,
  output logic [31:0] rd_data_1,
  output logic [31:0] rd_data_2,
  output logic [31:0] rd_data_3,
  output logic [31:0] rd_data_4,
  input  logic [3:0]  wr_addr_1,
  input  logic [3:0]  wr_addr_2,
  input  logic [31:0] wr_data_1,
  input  logic [31:0] wr_data_2,
  input  logic        wr_en_1,
  input  logic        wr_en_2,
  input  logic [31:0] pc_update,
  input  logic        pc_write,
  output logic [31:0] pc_out,
  input  logic [31:0] cpsr_update,
  input  logic        cpsr_write,
  output logic [31:0] cpsr_out
);

  logic [GPR_BITS-1:0] gpr_q, gpr_d;
  word_t               pc_q, pc_d;
  word_t               cpsr_q, cpsr_d;

  always_comb begin
    gpr_d = gpr_q;
    for (int i = 0; i < NUM_GPR; i++) begin
      if (wr_en_1 && (wr_addr_1 == reg_addr_t'(i))) begin
        gpr_d[i*32 +: 32] = wr_data_1;
      end else if (wr_en_2 && (wr_addr_2 == reg_addr_t'(i))) begin
        gpr_d[i*32 +: 32] = wr_data_2;
      end
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (pc_write) begin
      pc_d = align_pc(pc_update);
    end else if (wr_en_1 && (wr_addr_1 == REG_PC)) begin
      pc_d = align_pc(wr_data_1);
    end else if (wr_en_2 && (wr_addr_2 == REG_PC)) begin
      pc_d = align_pc(wr_data_2);
    end else if (pc_en) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_comb begin
    cpsr_d = cpsr_q;
    if (cpsr_write) begin
      cpsr_d = cpsr_update;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpr_q  <= '0;
      pc_q   <= PC_RESET;
      cpsr_q <= CPSR_RESET;
    end else begin
      gpr_q  <= gpr_d;
      pc_q   <= pc_d;
      cpsr_q <= cpsr_d;
    end
  end

  assign pc_out   = pc_q;
  assign cpsr_out = cpsr_q;

  logic [3:0]  rd_addr [4];
  logic [31:0] rd_data [4];

  assign rd_addr[0] = rd_addr_1;
  assign rd_addr[1] = rd_addr_2;
  assign rd_addr[2] = rd_addr_3;
  assign rd_addr[3] = rd_addr_4;

  assign rd_data_1 = rd_data[0];
  assign rd_data_2 = rd_data[1];
  assign rd_data_3 = rd_data[2];
  assign rd_data_4 = rd_data[3];

  for (genvar p = 0; p < 4; p++) begin : g_rd_port
    arm_rf_read_port u_rd_port (
      .rd_addr   (rd_addr[p]),
      .gpr       (gpr_q),
      .pc        (pc_q),
`ifdef ARM_RF_BYPASS_EN
      .pc_next   (pc_d),
      .wr_en_1   (wr_en_1),
      .wr_addr_1 (wr_addr_1),
      .wr_data_1 (wr_data_1),
      .wr_en_2   (wr_en_2),
      .wr_addr_2 (wr_addr_2),
      .wr_data_2 (wr_data_2),
`endif
      .rd_data   (rd_data[p])
    );
  end

endmodule

// File: tb/tb_arm_reg_bank.sv
// Self-checking bench for arm_reg_bank: vector table with a scoreboard plus reset/bypass sequences.
module tb_arm_reg_bank;

  logic        clk;
  logic        rst_n;
  logic        pc_en;
  logic [3:0]  rd_addr_1, rd_addr_2, rd_addr_3, rd_addr_4;
  logic [31:0] rd_data_1, rd_data_2, rd_data_3, rd_data_4;
  logic [3:0]  wr_addr_1, wr_addr_2;
  logic [31:0] wr_data_1, wr_data_2;
  logic        wr_en_1, wr_en_2;
  logic [31:0] pc_update;
  logic        pc_write;
  logic [31:0] pc_out;
  logic [31:0] cpsr_update;
  logic        cpsr_write;
  logic [31:0] cpsr_out;

  arm_reg_bank u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_en       (pc_en),
    .rd_addr_1   (rd_addr_1),
    .rd_addr_2   (rd_addr_2),
    .rd_addr_3   (rd_addr_3),
    .rd_addr_4   (rd_addr_4),
    .rd_data_1   (rd_data_1),
    .rd_data_2   (rd_data_2),
    .rd_data_3   (rd_data_3),
    .rd_data_4   (rd_data_4),
    .wr_addr_1   (wr_addr_1),
    .wr_addr_2   (wr_addr_2),
    .wr_data_1   (wr_data_1),
    .wr_data_2   (wr_data_2),
    .wr_en_1     (wr_en_1),
    .wr_en_2     (wr_en_2),
    .pc_update   (pc_update),
    .pc_write    (pc_write),
    .pc_out      (pc_out),
    .cpsr_update (cpsr_update),
    .cpsr_write  (cpsr_write),
    .cpsr_out    (cpsr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cpsr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] rd3;
    logic [31:0] rd4;
  } exp_t;

  typedef struct packed {
    logic        we1;
    logic [3:0]  wa1;
    logic [31:0] wd1;
    logic        we2;
    logic [3:0]  wa2;
    logic [31:0] wd2;
    logic        pc_en;
    logic        pc_wr;
    logic [31:0] pc_upd;
    logic        cpsr_wr;
    logic [31:0] cpsr_upd;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  ra3;
    logic [3:0]  ra4;
    exp_t        exp;
  } vec_t;

  localparam int NUM_VEC = 13;
  localparam logic [31:0] D3 = 32'h0000_00D3;
  localparam logic [31:0] CF = 32'h6000_001F;

`ifdef ARM_RF_BYPASS_EN
  localparam logic [31:0] R15_STEP_SEEN = 32'd4;
`else
  localparam logic [31:0] R15_STEP_SEEN = 32'd0;
`endif

  vec_t vecs [NUM_VEC];
  exp_t sb [$];
  int   n_vec;
  int   n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h", name, act, want);
    end
  endtask

  task automatic clear_strobes();
    wr_en_1    = 1'b0;
    wr_en_2    = 1'b0;
    pc_en      = 1'b0;
    pc_write   = 1'b0;
    cpsr_write = 1'b0;
  endtask

  task automatic apply_vec(input int idx);
    vec_t v;
    exp_t e;
    v = vecs[idx];
    @(negedge clk);
    wr_en_1 = v.we1; wr_addr_1 = v.wa1; wr_data_1 = v.wd1;
    wr_en_2 = v.we2; wr_addr_2 = v.wa2; wr_data_2 = v.wd2;
    pc_en = v.pc_en; pc_write = v.pc_wr; pc_update = v.pc_upd;
    cpsr_write = v.cpsr_wr; cpsr_update = v.cpsr_upd;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    clear_strobes();
    rd_addr_1 = v.ra1; rd_addr_2 = v.ra2; rd_addr_3 = v.ra3; rd_addr_4 = v.ra4;
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL v%0d scoreboard: got empty queue, want one entry", idx);
    end else begin
      e = sb.pop_front();
      check($sformatf("v%0d pc_out", idx), pc_out, e.pc);
      check($sformatf("v%0d cpsr_out", idx), cpsr_out, e.cpsr);
      check($sformatf("v%0d rd_data_1", idx), rd_data_1, e.rd1);
      check($sformatf("v%0d rd_data_2", idx), rd_data_2, e.rd2);
      check($sformatf("v%0d rd_data_3", idx), rd_data_3, e.rd3);
      check($sformatf("v%0d rd_data_4", idx), rd_data_4, e.rd4);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Starting point: PC = 8, all GPRs zero, CPSR = D3.
    vecs[0]  = '{1'b1, 4'd3, 32'hA5A5_0001, 1'b1, 4'd3, 32'h5A5A_0002, 1'b0, 1'b0, 32'h0, 1'b0,
                 32'h0, 4'd3, 4'd15, 4'd0, 4'd14,
                 '{32'h8, D3, 32'hA5A5_0001, 32'h10, 32'h0, 32'h0}};
    vecs[1]  = '{1'b1, 4'd0, 32'h1111_1111, 1'b1, 4'd14, 32'hEEEE_0000, 1'b0, 1'b0, 32'h0, 1'b0,
                 32'h0, 4'd0, 4'd14, 4'd3, 4'd15,
                 '{32'h8, D3, 32'h1111_1111, 32'hEEEE_0000, 32'hA5A5_0001, 32'h10}};
    vecs[2]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1,
                 CF, 4'd15, 4'd3, 4'd0, 4'd14,
                 '{32'hC, CF, 32'h14, 32'hA5A5_0001, 32'h1111_1111, 32'hEEEE_0000}};
    vecs[3]  = '{1'b1, 4'd15, 32'h0000_2000, 1'b1, 4'd5, 32'h55, 1'b1, 1'b1, 32'h0000_1003, 1'b0,
                 32'h0, 4'd15, 4'd5, 4'd3, 4'd0,
                 '{32'h1000, CF, 32'h1008, 32'h55, 32'hA5A5_0001, 32'h1111_1111}};
    vecs[4]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                 32'h0, 4'd15, 4'd5, 4'd14, 4'd0,
                 '{32'h1004, CF, 32'h100C, 32'h55, 32'hEEEE_0000, 32'h1111_1111}};
    vecs[5]  = '{1'b1, 4'd15, 32'h0000_2003, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                 32'h0, 4'd15, 4'd1, 4'd2, 4'd3,
                 '{32'h2000, CF, 32'h2008, 32'h0, 32'h0, 32'hA5A5_0001}};
    vecs[6]  = '{1'b1, 4'd1, 32'h1234, 1'b1, 4'd15, 32'h0000_3002, 1'b0, 1'b0, 32'h0, 1'b0,
                 32'h0, 4'd1, 4'd15, 4'd4, 4'd5,
                 '{32'h3000, CF, 32'h1234, 32'h3008, 32'h0, 32'h55}};
    vecs[7]  = '{1'b1, 4'd15, 32'h0000_4000, 1'b1, 4'd15, 32'h0000_5000, 1'b0, 1'b0, 32'h0, 1'b0,
                 32'h0, 4'd15, 4'd1, 4'd6, 4'd7,
                 '{32'h4000, CF, 32'h4008, 32'h1234, 32'h0, 32'h0}};
    vecs[8]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0,
                 32'h0, 4'd15, 4'd2, 4'd3, 4'd14,
                 '{32'hFFFF_FFFC, CF, 32'h4, 32'h0, 32'hA5A5_0001, 32'hEEEE_0000}};
    vecs[9]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                 32'h0, 4'd15, 4'd0, 4'd1, 4'd5,
                 '{32'h0, CF, 32'h8, 32'h1111_1111, 32'h1234, 32'h55}};
    vecs[10] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                 32'h0, 4'd2, 4'd14, 4'd15, 4'd3,
                 '{32'h0, CF, 32'h0, 32'hEEEE_0000, 32'h8, 32'hA5A5_0001}};
    vecs[11] = '{1'b0, 4'd2, 32'hDEAD_DEAD, 1'b0, 4'd4, 32'hBEEF, 1'b0, 1'b0, 32'h0, 1'b0,
                 32'h0, 4'd2, 4'd4, 4'd0, 4'd15,
                 '{32'h0, CF, 32'h0, 32'h0, 32'h1111_1111, 32'h8}};
    vecs[12] = '{1'b1, 4'd7, 32'h7777, 1'b1, 4'd6, 32'h6666, 1'b0, 1'b0, 32'h0, 1'b0,
                 32'h0, 4'd6, 4'd7, 4'd15, 4'd3,
                 '{32'h0, CF, 32'h6666, 32'h7777, 32'h8, 32'hA5A5_0001}};

    // Reset and release with pc_en held high.
    rst_n = 1'b0;
    clear_strobes();
    pc_en = 1'b1;
    wr_addr_1 = 4'd0; wr_data_1 = 32'h0; wr_addr_2 = 4'd0; wr_data_2 = 32'h0;
    pc_update = 32'h0; cpsr_update = 32'h0;
    rd_addr_1 = 4'd15; rd_addr_2 = 4'd3; rd_addr_3 = 4'd14; rd_addr_4 = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset pc_out", pc_out, 32'h0);
    check("reset cpsr_out", cpsr_out, D3);
    check("reset r15 read", rd_data_1, 32'h8 + R15_STEP_SEEN);
    check("reset r3 read", rd_data_2, 32'h0);
    check("reset r14 read", rd_data_3, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release pc_out before edge", pc_out, 32'h0);
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("run edge%0d pc_out", k), pc_out, 32'(4 * k));
      check($sformatf("run edge%0d r15 read", k), rd_data_1, 32'(4 * k + 8) + R15_STEP_SEEN);
      check($sformatf("run edge%0d cpsr_out", k), cpsr_out, D3);
    end
    pc_en = 1'b0;

    for (int i = 0; i < NUM_VEC; i++) begin
      apply_vec(i);
    end

    // Same-cycle read of a register being written.
    @(negedge clk);
    rd_addr_2 = 4'd7;
    wr_en_1 = 1'b1; wr_addr_1 = 4'd7; wr_data_1 = 32'hDEAD_BEEF;
    #1;
`ifdef ARM_RF_BYPASS_EN
    check("bypass r7 same cycle", rd_data_2, 32'hDEAD_BEEF);
`else
    check("bypass r7 same cycle", rd_data_2, 32'h7777);
`endif
    @(posedge clk);
    #1;
    clear_strobes();
    #1;
    check("bypass r7 after edge", rd_data_2, 32'hDEAD_BEEF);

    // Asynchronous reset between edges.
    @(negedge clk);
    wr_en_1 = 1'b1; wr_addr_1 = 4'd1; wr_data_1 = 32'h1234;
    cpsr_write = 1'b1; cpsr_update = CF;
    @(posedge clk);
    #1;
    clear_strobes();
    rd_addr_1 = 4'd1; rd_addr_2 = 4'd2;
    #1;
    check("pre-reset r1", rd_data_1, 32'h1234);
    check("pre-reset cpsr", cpsr_out, CF);
    #1;
    wr_en_1 = 1'b1; wr_addr_1 = 4'd2; wr_data_1 = 32'h99;
    pc_en = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async reset r1", rd_data_1, 32'h0);
    check("async reset cpsr", cpsr_out, D3);
    check("async reset pc", pc_out, 32'h0);
    @(posedge clk);
    #1;
    clear_strobes();
    #1;
    check("reset held r2 write dropped", rd_data_2, 32'h0);
    check("reset held pc", pc_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pc_en = 1'b1;
    #1;
    check("re-release pc before edge", pc_out, 32'h0);
    @(posedge clk);
    #1;
    check("re-release first edge pc", pc_out, 32'h4);
    check("re-release r2", rd_data_2, 32'h0);
    pc_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arm_reg_bank.md
ARM_REG_BANK -- requirements
Module: arm_reg_bank

Interface
REQ-001 The block SHALL provide parameter PC_RESET, default 32'h0000_0000, meaning the PC value loaded at reset.
REQ-002 The block SHALL provide parameter CPSR_RESET, default 32'h0000_00D3, meaning the CPSR reset value (SVC mode, IRQ and FIQ masked).
REQ-003 The block SHALL have these ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- pc_en  input  1  PC auto-increment enable (pipeline not stalled).
- rd_addr_1..rd_addr_4  input  4 each  read port register selects.
- rd_data_1..rd_data_4  output  32 each  read port data.
- wr_addr_1, wr_addr_2  input  4 each  write port register selects.
- wr_data_1, wr_data_2  input  32 each  write port data.
- wr_en_1, wr_en_2  input  1 each  write port enables.
- pc_update  input  32  explicit PC load value (branch target).
- pc_write  input  1  explicit PC load strobe.
- pc_out  output  32  current PC (fetch address).
- cpsr_update  input  32  CPSR load value.
- cpsr_write  input  1  CPSR load strobe.
- cpsr_out  output  32  current CPSR.

Function
REQ-004 The block SHALL hold 15 general registers R0-R14 (32 bits each) plus a PC register that is R15.
REQ-005 Reads SHALL be combinational; with rd_addr_n in 0..14 the result SHALL be the register contents, and with rd_addr_n = 15 the result SHALL be PC + 8 (ARM7 pipeline offset, modulo 2^32).
REQ-006 With wr_en_n high, register wr_addr_n (0..14) SHALL take wr_data_n at the next rising edge.
REQ-007 If both write ports target the same register in one cycle, port 1 SHALL win and port 2's write SHALL be dropped.
REQ-008 The PC next-state priority SHALL be: pc_write (pc_update), then a port write to R15 (port 1 before port 2), then pc_en (PC + 4, wrapping at 2^32), otherwise hold.
REQ-009 Bits [1:0] of any PC load SHALL be forced to 0.
REQ-010 With cpsr_write high, CPSR SHALL take cpsr_update at the next edge; otherwise it SHALL hold.
REQ-011 pc_out and cpsr_out SHALL reflect the registered values directly, with no combinational path from any input.
REQ-012 Write-to-read latency SHALL be one cycle: a value written at edge k SHALL be visible on the reads from edge k onward.

Reset
REQ-013 While rst_n is low: R0-R14 SHALL be 0, PC SHALL be PC_RESET, and CPSR SHALL be CPSR_RESET, regardless of clk.
REQ-014 Reset asserted mid-cycle SHALL discard pending writes; the first update after release SHALL occur at the first rising edge with rst_n high.

Configuration
REQ-015 With macro ARM_RF_BYPASS_EN defined, a read whose address matches an enabled same-cycle write SHALL return the incoming write data, with port 1 data when both ports match.
REQ-016 With ARM_RF_BYPASS_EN defined, a read of R15 SHALL return the next-state PC + 8.
REQ-017 Without ARM_RF_BYPASS_EN, reads SHALL return only registered state (the REQ-005 behaviour).

Structure
REQ-018 Package arm_pkg SHALL hold: typedef reg_addr_t (4 bits), typedef word_t (32 bits), constants REG_PC = 15, REG_LR = 14, PC_READ_OFFSET = 8, and PC_STEP = 4.
REQ-019 One sub-module, arm_rf_read_port (address in, data out, with the optional bypass compare), SHALL be instantiated four times.

Verification
REQ-020 Reset test: release rst_n with pc_en = 1 -> pc_out = 0, 4, 8 on successive edges; cpsr_out = 32'hD3; rd_addr_1 = 15 reads 8, 12, 16.
REQ-021 Port collision test: wr_en_1 = wr_en_2 = 1, both addresses 3, data A5A5_0001 / 5A5A_0002 -> R3 = A5A5_0001.
REQ-022 PC priority test: pc_write = 1 with pc_update = 0000_1003, a port-1 write to R15 of 0000_2000, and pc_en = 1 -> pc_out = 0000_1000; the next cycle with pc_en only -> 0000_1004.
REQ-023 PC wrap test: PC = FFFF_FFFC with pc_en = 1 -> PC = 0000_0000; a read of R15 then returns 0000_0008.
REQ-024 Bypass test: write R7 = DEAD_BEEF while rd_addr_2 = 7 -> DEAD_BEEF in the same cycle with ARM_RF_BYPASS_EN defined; the old value of R7 without it.
REQ-025 Asynchronous reset test: drop rst_n between edges after writing R1 = 1234 and CPSR = 6000_001F -> R1 = 0, CPSR = D3, and PC = PC_RESET immediately, without waiting for a clock edge.
